// File: rtl/crossing_pkg.sv
// Shared types and timing defaults for the level-crossing controllers
// (approach-side monitor and far-end exit controller).
package crossing_pkg;

  // Default timing, shared with the approach monitor so both ends agree.
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_WARN_CYCLES     = 8;
  localparam int DEF_RAISE_CYCLES    = 6;
  localparam int DEF_FLASH_HALF      = 2;
  localparam int DEF_MAX_TRAINS      = 3;
  localparam int DEF_TIMEOUT_CYCLES  = 200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARN   = 3'd1,
    ST_CLOSED = 3'd2,
    ST_RAISE  = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  // Width of a down-counter able to hold the largest of the given loads.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// The stable level flips only after DEBOUNCE_CYCLES consecutive synchronised
// samples that disagree with it; any agreeing sample reloads the count.
module sensor_debounce
  import crossing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int DW = timer_width(DEBOUNCE_CYCLES, 1, 1, 1);
  localparam logic [DW-1:0] RELOAD = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] ONE    = DW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // Synchroniser shift and debounce down-counter with terminal-count compare.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = RELOAD;
    if (sync2_q != stable_q) begin
      if (cnt_q == '0) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // Register stage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= RELOAD;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/crossing_exit_ctrl.sv
// Far-end level-crossing controller: counts trains in the section from the
// approach indication and the debounced exit sensor, and sequences warning
// lamp, barrier and clear lamp. Optional exit-sensor watchdog in CLOSED is
// built when CROSSING_TIMEOUT_EN is defined.
//
//   state  | meaning
//   IDLE   | section empty, barrier up, clear lamp on
//   WARN   | train announced, lamp flashing, barrier still up
//   CLOSED | barrier down, lamp flashing, waiting for section to empty
//   RAISE  | section empty, lamp steady, hold before barrier goes up
//   FAULT  | count inconsistency or stuck sensor; barrier down until reset
module crossing_exit_ctrl
  import crossing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WARN_CYCLES     = DEF_WARN_CYCLES,
  parameter int RAISE_CYCLES    = DEF_RAISE_CYCLES,
  parameter int FLASH_HALF      = DEF_FLASH_HALF,
  parameter int MAX_TRAINS      = DEF_MAX_TRAINS
`ifdef CROSSING_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               approach,
  input  logic                               sw2,
  output logic                               gate_down,
  output logic                               warn_led,
  output logic                               clear_led,
  output logic [$clog2(MAX_TRAINS+1)-1:0]    occ,
  output logic                               fault
);

  localparam int CW = $clog2(MAX_TRAINS + 1);
  localparam int TW = timer_width(WARN_CYCLES, RAISE_CYCLES, FLASH_HALF, DEBOUNCE_CYCLES);

  localparam logic [CW-1:0] OCC_MAX    = CW'(MAX_TRAINS);
  localparam logic [CW-1:0] OCC_ONE    = CW'(1);
  localparam logic [TW-1:0] TW_ONE     = TW'(1);
  localparam logic [TW-1:0] WARN_LOAD  = TW'(WARN_CYCLES - 1);
  localparam logic [TW-1:0] RAISE_LOAD = TW'(RAISE_CYCLES - 1);
  localparam logic [TW-1:0] FLASH_LOAD = TW'(FLASH_HALF - 1);

`ifdef CROSSING_TIMEOUT_EN
  localparam int WW = timer_width(TIMEOUT_CYCLES, 1, 1, 1);
  localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WW_ONE  = WW'(1);
  logic [WW-1:0] wd_q, wd_d;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] flash_q, flash_d;
  logic          gate_down_q, gate_down_d;
  logic          warn_led_q, warn_led_d;
  logic          clear_led_q, clear_led_d;
  logic          fault_q, fault_d;
  logic          approach_q;
  logic          ext_prev_q;

  logic dbnc_stable;
  logic ent, ext, ent_only, ext_only;
  logic underflow, overflow;
  logic flashing_before;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw2_dbnc (
    .clk    (clk),
    .reset  (reset),
    .raw    (sw2),
    .stable (dbnc_stable)
  );

  // Edge detection and occupancy update; the count freezes once in FAULT.
  always_comb begin
    ent       = approach & ~approach_q;
    ext       = dbnc_stable & ~ext_prev_q;
    ent_only  = ent & ~ext;
    ext_only  = ext & ~ent;
    underflow = ext_only && (occ_q == '0);
    overflow  = ent_only && (occ_q == OCC_MAX);
    occ_d     = occ_q;
    if ((state_q != ST_FAULT) && !underflow && !overflow) begin
      if (ent_only) begin
        occ_d = occ_q + OCC_ONE;
      end else if (ext_only) begin
        occ_d = occ_q - OCC_ONE;
      end
    end
  end

  // Next-state logic; sequence timers count down and hold at zero.
  always_comb begin
    state_d = state_q;
    timer_d = (timer_q != '0) ? timer_q - TW_ONE : timer_q;
`ifdef CROSSING_TIMEOUT_EN
    wd_d    = (wd_q != '0) ? wd_q - WW_ONE : wd_q;
`endif
    if ((state_q != ST_FAULT) && (underflow || overflow)) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ent) begin
            state_d = ST_WARN;
            timer_d = WARN_LOAD;
          end
        end
        ST_WARN: begin
          // Extra entries here only bump occ; the warning time is not extended.
          if (timer_q == '0) begin
            state_d = ST_CLOSED;
`ifdef CROSSING_TIMEOUT_EN
            wd_d    = WD_LOAD;
`endif
          end
        end
        ST_CLOSED: begin
          if (occ_d == '0) begin
            state_d = ST_RAISE;
            timer_d = RAISE_LOAD;
          end
`ifdef CROSSING_TIMEOUT_EN
          else if (occ_d != occ_q) begin
            wd_d = WD_LOAD;
          end else if (wd_q == '0) begin
            state_d = ST_FAULT;
          end
`endif
        end
        ST_RAISE: begin
          // A new train while the barrier is still down needs no fresh warning.
          if (ent) begin
            state_d = ST_CLOSED;
`ifdef CROSSING_TIMEOUT_EN
            wd_d    = WD_LOAD;
`endif
          end else if (timer_q == '0) begin
            state_d = ST_IDLE;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_FAULT;
        end
      endcase
    end
  end

  // Output decode from the next state so every output is registered.
  always_comb begin
    gate_down_d     = 1'b0;
    warn_led_d      = 1'b0;
    clear_led_d     = 1'b0;
    fault_d         = 1'b0;
    flash_d         = flash_q;
    flashing_before = (state_q == ST_WARN) || (state_q == ST_CLOSED);
    case (state_d)
      ST_IDLE: begin
        clear_led_d = 1'b1;
      end
      ST_WARN, ST_CLOSED: begin
        gate_down_d = (state_d == ST_CLOSED);
        if (!flashing_before) begin
          warn_led_d = 1'b1;
          flash_d    = FLASH_LOAD;
        end else if (flash_q == '0) begin
          warn_led_d = ~warn_led_q;
          flash_d    = FLASH_LOAD;
        end else begin
          warn_led_d = warn_led_q;
          flash_d    = flash_q - TW_ONE;
        end
      end
      ST_RAISE: begin
        gate_down_d = 1'b1;
        warn_led_d  = 1'b1;
      end
      ST_FAULT: begin
        gate_down_d = 1'b1;
        warn_led_d  = 1'b1;
        fault_d     = 1'b1;
      end
      default: begin
        gate_down_d = 1'b1;
        warn_led_d  = 1'b1;
        fault_d     = 1'b1;
      end
    endcase
  end

  // State register; edge registers load the current level during reset so a
  // level already high is not counted as a new edge on release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      occ_q       <= '0;
      timer_q     <= '0;
      flash_q     <= '0;
      gate_down_q <= 1'b0;
      warn_led_q  <= 1'b0;
      clear_led_q <= 1'b1;
      fault_q     <= 1'b0;
      approach_q  <= approach;
      ext_prev_q  <= dbnc_stable;
`ifdef CROSSING_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      timer_q     <= timer_d;
      flash_q     <= flash_d;
      gate_down_q <= gate_down_d;
      warn_led_q  <= warn_led_d;
      clear_led_q <= clear_led_d;
      fault_q     <= fault_d;
      approach_q  <= approach;
      ext_prev_q  <= dbnc_stable;
`ifdef CROSSING_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign gate_down = gate_down_q;
  assign warn_led  = warn_led_q;
  assign clear_led = clear_led_q;
  assign occ       = occ_q;
  assign fault     = fault_q;

endmodule
